// File: rtl/seg_scan_if.sv
// Bus between a display source and seg_scan_driver: frame data in, scanned pins out.
// Interface contract: load is a 1-cycle strobe and is always accepted. load_ack pulses
// once when the latest loaded frame becomes visible. No backpressure is applied.
interface seg_scan_if #(
  parameter int DIGITS = 4
);
  logic                  en;
  logic                  load;
  logic [4*DIGITS-1:0]   din;
  logic [DIGITS-1:0]     dp_in;
  logic [DIGITS-1:0]     blank_in;
  logic [7:0]            seg;
  logic [DIGITS-1:0]     an;
  logic                  frame_tick;
  logic                  load_ack;

  modport master (
    output en, load, din, dp_in, blank_in,
    input  seg, an, frame_tick, load_ack
  );

  modport slave (
    input  en, load, din, dp_in, blank_in,
    output seg, an, frame_tick, load_ack
  );
endinterface

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 7-segment scan driver with frame-boundary double buffering.
// Optional macro SEG_HEX_DECODE_EN: decode nibbles 10-15 as hex glyphs A b C d E F.
module seg_scan_driver #(
  parameter int DIGITS  = 4,
  parameter int CLK_DIV = 1000,
  parameter int IDX_W   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  seg_scan_if.slave   bus
);

  localparam int CNT_W = $clog2(CLK_DIV);

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                wrap;

  logic [4*DIGITS-1:0] disp_val_q, disp_val_d, pend_val_q, pend_val_d;
  logic [DIGITS-1:0]   disp_dp_q, disp_dp_d, pend_dp_q, pend_dp_d;
  logic [DIGITS-1:0]   disp_blank_q, disp_blank_d, pend_blank_q, pend_blank_d;
  logic                pend_vld_q, pend_vld_d;

  logic [7:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic                frame_tick_q, load_ack_q, load_ack_d;

  logic [3:0]          cur_nib;
  logic                cur_dp, cur_blank;

  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1111110;
      4'h1: s = 7'b0110000;
      4'h2: s = 7'b1101101;
      4'h3: s = 7'b1111001;
      4'h4: s = 7'b0110011;
      4'h5: s = 7'b1011011;
      4'h6: s = 7'b1011111;
      4'h7: s = 7'b1110000;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1111011;
`ifdef SEG_HEX_DECODE_EN
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b0011111;
      4'hC: s = 7'b1001110;
      4'hD: s = 7'b0111101;
      4'hE: s = 7'b1001111;
      4'hF: s = 7'b1000111;
`endif
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  // Prescaler and digit index; wrap marks the frame boundary edge.
  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    wrap  = 1'b0;
    if (bus.en) begin
      if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
        cnt_d = '0;
        if (idx_q == IDX_W'(DIGITS - 1)) begin
          idx_d = '0;
          wrap  = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // A load landing on the wrap edge bypasses the pending buffer entirely.
  always_comb begin
    disp_val_d   = disp_val_q;
    disp_dp_d    = disp_dp_q;
    disp_blank_d = disp_blank_q;
    pend_val_d   = pend_val_q;
    pend_dp_d    = pend_dp_q;
    pend_blank_d = pend_blank_q;
    pend_vld_d   = pend_vld_q;
    load_ack_d   = 1'b0;
    if (wrap) begin
      if (bus.load) begin
        disp_val_d   = bus.din;
        disp_dp_d    = bus.dp_in;
        disp_blank_d = bus.blank_in;
        pend_vld_d   = 1'b0;
        load_ack_d   = 1'b1;
      end else if (pend_vld_q) begin
        disp_val_d   = pend_val_q;
        disp_dp_d    = pend_dp_q;
        disp_blank_d = pend_blank_q;
        pend_vld_d   = 1'b0;
        load_ack_d   = 1'b1;
      end
    end else if (bus.load) begin
      pend_val_d   = bus.din;
      pend_dp_d    = bus.dp_in;
      pend_blank_d = bus.blank_in;
      pend_vld_d   = 1'b1;
    end
  end

  always_comb begin
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    an_d      = '0;
    seg_d     = 8'h00;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        cur_nib   = disp_val_q[4*k +: 4];
        cur_dp    = disp_dp_q[k];
        cur_blank = disp_blank_q[k];
      end
    end
    if (bus.en) begin
      for (int k = 0; k < DIGITS; k++) begin
        an_d[k] = (idx_q == IDX_W'(k));
      end
      if (!cur_blank) begin
        seg_d = {decode(cur_nib), cur_dp};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      disp_val_q   <= '0;
      disp_dp_q    <= '0;
      disp_blank_q <= '0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_blank_q <= '0;
      pend_vld_q   <= 1'b0;
      seg_q        <= 8'h00;
      an_q         <= '0;
      frame_tick_q <= 1'b0;
      load_ack_q   <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      disp_val_q   <= disp_val_d;
      disp_dp_q    <= disp_dp_d;
      disp_blank_q <= disp_blank_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_blank_q <= pend_blank_d;
      pend_vld_q   <= pend_vld_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_tick_q <= wrap;
      load_ack_q   <= load_ack_d;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.an         = an_q;
  assign bus.frame_tick = frame_tick_q;
  assign bus.load_ack   = load_ack_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: directed scenarios plus random traffic against a
// position-based reference model of the scanned display.
module tb_seg_scan_driver;
  localparam int DIGITS  = 4;
  localparam int CLK_DIV = 4;
  localparam int IDX_W   = 2;
  localparam int N       = DIGITS * CLK_DIV;
  localparam int W       = DIGITS + 10;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seg_scan_if #(.DIGITS(DIGITS)) bus ();

  seg_scan_driver #(.DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .IDX_W(IDX_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // reference model: scan position within a frame plus shown/pending frames
  int                  pos;
  logic [4*DIGITS-1:0] m_val, p_val;
  logic [DIGITS-1:0]   m_dp, p_dp, m_blank, p_blank;
  bit                  p_vld;
  bit                  m_ack;
  logic [W-1:0]        exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int ack_cnt;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1111110;
      4'h1: return 7'b0110000;
      4'h2: return 7'b1101101;
      4'h3: return 7'b1111001;
      4'h4: return 7'b0110011;
      4'h5: return 7'b1011011;
      4'h6: return 7'b1011111;
      4'h7: return 7'b1110000;
      4'h8: return 7'b1111111;
      4'h9: return 7'b1111011;
`ifdef SEG_HEX_DECODE_EN
      4'hA: return 7'b1110111;
      4'hB: return 7'b0011111;
      4'hC: return 7'b1001110;
      4'hD: return 7'b0111101;
      4'hE: return 7'b1001111;
      4'hF: return 7'b1000111;
`endif
      default: return 7'b0000000;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Predict the outputs that the coming clock edge will register.
  task automatic model_edge();
    int d;
    logic [DIGITS-1:0] an_e;
    logic [7:0]        seg_e;
    bit                wrap;
    if (!rst_n) begin
      pos = 0; m_val = '0; m_dp = '0; m_blank = '0;
      p_val = '0; p_dp = '0; p_blank = '0; p_vld = 0; m_ack = 0;
      exp_q.push_back('0);
      return;
    end
    d     = pos / CLK_DIV;
    an_e  = bus.en ? DIGITS'(1 << d) : '0;
    seg_e = (bus.en && !m_blank[d]) ? {glyph(m_val[4*d +: 4]), m_dp[d]} : 8'h00;
    wrap  = bus.en && (pos == N - 1);
    m_ack = 0;
    if (wrap && bus.load) begin
      m_val = bus.din; m_dp = bus.dp_in; m_blank = bus.blank_in;
      p_vld = 0; m_ack = 1;
    end else if (wrap && p_vld) begin
      m_val = p_val; m_dp = p_dp; m_blank = p_blank;
      p_vld = 0; m_ack = 1;
    end else if (!wrap && bus.load) begin
      p_val = bus.din; p_dp = bus.dp_in; p_blank = bus.blank_in; p_vld = 1;
    end
    if (bus.en) pos = (pos + 1) % N;
    exp_q.push_back({an_e, seg_e, wrap, m_ack});
  endtask

  // driver: one clock with model prediction and full output comparison
  task automatic step();
    logic [W-1:0] e;
    model_edge();
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("an",         32'(bus.an),         32'(e[W-1 -: DIGITS]));
    check("seg",        32'(bus.seg),        32'(e[9:2]));
    check("frame_tick", 32'(bus.frame_tick), 32'(e[1]));
    check("load_ack",   32'(bus.load_ack),   32'(e[0]));
    ack_cnt += int'(bus.load_ack);
  endtask

  task automatic advance_to(input int p);
    for (int i = 0; i < N + 1 && pos != p; i++) step();
    check("advance_to", 32'(pos), 32'(p));
  endtask

  task automatic do_load(input logic [4*DIGITS-1:0] v, input logic [DIGITS-1:0] dp,
                         input logic [DIGITS-1:0] bl);
    bus.din = v; bus.dp_in = dp; bus.blank_in = bl; bus.load = 1'b1;
    step();
    bus.load = 1'b0;
  endtask

  task automatic wait_ack();
    for (int i = 0; i < N + 1 && !m_ack; i++) step();
    check("ack_seen", 32'(bus.load_ack), 32'd1);
  endtask

  initial begin
    logic [7:0] dig_exp [DIGITS];
    logic [7:0] hex_a;
    ack_cnt = 0;
    rst_n = 1'b0;
    bus.en = 1'b0; bus.load = 1'b0; bus.din = '0; bus.dp_in = '0; bus.blank_in = '0;
    repeat (3) step();

    // first lit output after reset is digit 0 showing "0"
    rst_n = 1'b1;
    bus.en = 1'b1;
    step();
    check("first_an", 32'(bus.an), 32'h1);
    check("first_seg", 32'(bus.seg), 32'hFC);
    repeat (40) step();

    // mid-frame load shows only after the wrap
    advance_to(6);
    do_load(16'h4321, 4'b0010, 4'b0000);
    wait_ack();
    dig_exp[0] = 8'h60; dig_exp[1] = 8'hDB; dig_exp[2] = 8'hF2; dig_exp[3] = 8'h66;
    for (int d = 0; d < DIGITS; d++) begin
      step();
      check("digit_4321", 32'(bus.seg), 32'(dig_exp[d]));
      repeat (CLK_DIV - 1) step();
    end

    // two loads before a wrap: last one wins, single ack
    advance_to(3);
    do_load(16'h1111, 4'b0000, 4'b0000);
    do_load(16'h9999, 4'b0000, 4'b0000);
    ack_cnt = 0;
    repeat (N + 2) step();
    check("one_ack", 32'(ack_cnt), 32'd1);

    // load on the wrap cycle goes straight to the frame that is starting
    advance_to(N - 1);
    do_load(16'h5555, 4'b1111, 4'b0000);
    check("wrap_load_ack", 32'(bus.load_ack), 32'd1);
    step();
    check("wrap_load_seg", 32'(bus.seg), 32'hB7);
    repeat (N) step();

    // blanked digit 3, then freeze mid-slot and resume
    advance_to(N - 1);
    do_load(16'h0000, 4'b0000, 4'b1000);
    repeat (N) step();
    advance_to(2);
    bus.en = 1'b0;
    step();
    check("frozen_an", 32'(bus.an), 32'h0);
    check("frozen_seg", 32'(bus.seg), 32'h0);
    repeat (4) step();
    bus.en = 1'b1;
    repeat (N + 4) step();

    // nibble A decodes only in hex builds
    advance_to(N - 1);
    do_load(16'h000A, 4'b0000, 4'b0000);
    step();
`ifdef SEG_HEX_DECODE_EN
    hex_a = 8'hEE;
`else
    hex_a = 8'h00;
`endif
    check("hex_a", 32'(bus.seg), 32'(hex_a));

    // reset mid-frame drops pending data
    advance_to(5);
    do_load(16'h7777, 4'b1111, 4'b0000);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    ack_cnt = 0;
    repeat (N + 4) step();
    check("no_ack_after_reset", 32'(ack_cnt), 32'd0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      bus.en       = ($urandom_range(0, 7) != 0);
      bus.load     = ($urandom_range(0, 5) == 0);
      bus.din      = 16'($urandom);
      bus.dp_in    = 4'($urandom_range(0, 15));
      bus.blank_in = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
